instruction_fetch_unit: RTL and testbench

//  IF stage of the RV32IM pipeline, directly downstream of the PC register. Takes the current PC,

---
 rtl/rv32_fetch_pkg.sv | 18 +
 rtl/fetch_fifo.sv | 51 +++++
 rtl/instruction_fetch_unit.sv | 109 ++++++++++
 tb/tb_instruction_fetch_unit.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/rv32_fetch_pkg.sv
// Shared types and constants for the RV32 instruction fetch stage.
package rv32_fetch_pkg;

    // ADDI x0,x0,0: what decode sees when no fetched instruction is available
    localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE,   // no memory request outstanding
        REQ,    // request outstanding, result will be queued
        DRAIN   // request outstanding, result belongs to a squashed path
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Circular queue of fetched instructions with their fetch addresses.
module fetch_fifo
    import rv32_fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                     CLOCK,
    input  logic                     RESET,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  fetch_entry_t             push_data,
    output logic [$clog2(DEPTH):0]   count,
    output fetch_entry_t             head
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    fetch_entry_t  mem_q [DEPTH];
    logic [PW-1:0] head_q;
    logic [PW-1:0] tail_q;
    logic [CW-1:0] count_q;

    // Pointer and occupancy update; flush empties the queue in one edge
    always_ff @(posedge CLOCK) begin
        if (RESET || flush) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (push) tail_q <= tail_q + 1'b1;
            if (pop)  head_q <= head_q + 1'b1;
            count_q <= count_q + CW'(push) - CW'(pop);
        end
    end

    // Entry storage; pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge CLOCK) begin
        if (push && !RESET && !flush) begin
            mem_q[tail_q] <= push_data;
        end
    end

    // Head and occupancy straight from state
    always_comb begin
        count = count_q;
        head  = mem_q[head_q];
    end

endmodule

// File: rtl/instruction_fetch_unit.sv
// IF stage: issues instruction memory reads for the current PC, queues the
// returned words for decode, and squashes wrong-path fetches on redirect.
module instruction_fetch_unit
    import rv32_fetch_pkg::*;
#(
    parameter int unsigned DEPTH     = 2,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic        CLOCK,
    input  logic        RESET,
    input  logic [31:0] PC,
    output logic [31:0] PC_NEXT,
    output logic        FETCH_STALL,
    output logic        IMEM_READ,
    output logic [31:0] IMEM_ADDR,
    input  logic [31:0] IMEM_READDATA,
    input  logic        IMEM_BUSYWAIT,
    input  logic        BRANCH_TAKEN,
    input  logic [31:0] BRANCH_TARGET,
    input  logic        ID_STALL,
    output logic        IF_VALID,
    output logic [31:0] IF_INSTR,
    output logic [31:0] IF_PC,
    output logic [31:0] IF_PC4
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    fetch_state_t  state_q;
    logic [CW-1:0] count;
    logic [CW-1:0] count_next;
    fetch_entry_t  head;
    fetch_entry_t  push_data;
    logic          complete;
    logic          push;
    logic          pop;
    logic          issue;

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .CLOCK     (CLOCK),
        .RESET     (RESET),
        .push      (push),
        .pop       (pop),
        .flush     (BRANCH_TAKEN),
        .push_data (push_data),
        .count     (count),
        .head      (head)
    );

    // Handshake decode and issue decision; a draining request never re-issues
    always_comb begin
        complete   = (state_q != IDLE) && IMEM_READ && !IMEM_BUSYWAIT;
        push       = complete && (state_q == REQ) && !BRANCH_TAKEN;
        pop        = (count != '0) && !ID_STALL && !BRANCH_TAKEN;
        count_next = count + CW'(push) - CW'(pop);
        issue      = !RESET && !BRANCH_TAKEN
                     && ((state_q == IDLE) || (complete && (state_q == REQ)))
                     && (count_next < CW'(DEPTH));
        push_data.pc    = IMEM_ADDR;
        push_data.instr = IMEM_READDATA;
    end

    // PC register control and decode-facing outputs
    always_comb begin
        PC_NEXT     = BRANCH_TAKEN ? BRANCH_TARGET : PC + 32'd4;
        FETCH_STALL = RESET || (!issue && !BRANCH_TAKEN);
        IF_VALID    = (count != '0);
        IF_INSTR    = IF_VALID ? head.instr : NOP_INSTR;
        IF_PC       = IF_VALID ? head.pc : 32'd0;
        IF_PC4      = IF_PC + 32'd4;
    end

    // Request FSM with registered memory interface
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state_q   <= IDLE;
            IMEM_READ <= 1'b0;
            IMEM_ADDR <= 32'd0;
        end else if (issue) begin
            state_q   <= REQ;
            IMEM_READ <= 1'b1;
            IMEM_ADDR <= PC;
        end else begin
            case (state_q)
                REQ: begin
                    if (complete) begin
                        state_q   <= IDLE;
                        IMEM_READ <= 1'b0;
                    end else if (BRANCH_TAKEN) begin
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (complete) begin
                        state_q   <= IDLE;
                        IMEM_READ <= 1'b0;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    IMEM_READ <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Randomized bench for instruction_fetch_unit against a transaction-level model:
// one outstanding-request record, a queue of (pc, instr) pairs and a PC register.
module tb_instruction_fetch_unit;

    localparam int DEPTH = 2;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        CLOCK = 1'b0;
    logic        RESET = 1'b1;
    logic [31:0] PC = '0;
    logic [31:0] PC_NEXT;
    logic        FETCH_STALL;
    logic        IMEM_READ;
    logic [31:0] IMEM_ADDR;
    logic [31:0] IMEM_READDATA = '0;
    logic        IMEM_BUSYWAIT = 1'b0;
    logic        BRANCH_TAKEN = 1'b0;
    logic [31:0] BRANCH_TARGET = '0;
    logic        ID_STALL = 1'b0;
    logic        IF_VALID;
    logic [31:0] IF_INSTR;
    logic [31:0] IF_PC;
    logic [31:0] IF_PC4;

    instruction_fetch_unit #(
        .DEPTH     (DEPTH),
        .NOP_INSTR (NOP)
    ) dut (
        .CLOCK         (CLOCK),
        .RESET         (RESET),
        .PC            (PC),
        .PC_NEXT       (PC_NEXT),
        .FETCH_STALL   (FETCH_STALL),
        .IMEM_READ     (IMEM_READ),
        .IMEM_ADDR     (IMEM_ADDR),
        .IMEM_READDATA (IMEM_READDATA),
        .IMEM_BUSYWAIT (IMEM_BUSYWAIT),
        .BRANCH_TAKEN  (BRANCH_TAKEN),
        .BRANCH_TARGET (BRANCH_TARGET),
        .ID_STALL      (ID_STALL),
        .IF_VALID      (IF_VALID),
        .IF_INSTR      (IF_INSTR),
        .IF_PC         (IF_PC),
        .IF_PC4        (IF_PC4)
    );

    always #5 CLOCK = ~CLOCK;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    // Model state
    ent_t        q[$];
    logic        m_busy  = 1'b0;   // a request is open
    logic        m_wrong = 1'b0;   // open request was squashed by a redirect
    logic [31:0] m_addr  = '0;
    logic [31:0] m_pc    = '0;

    int n_checks = 0;
    int n_bad    = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9bdf;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock: drive inputs after negedge, compare, then advance the model at posedge
    task automatic step(input logic rst, input logic bw, input logic ids, input logic br,
                        input logic [31:0] tgt);
        logic        complete, push, pop, issue, stall;
        logic [31:0] pc_next;
        int          cnt_next;
        @(negedge CLOCK);
        RESET         = rst;
        IMEM_BUSYWAIT = bw;
        ID_STALL      = ids;
        BRANCH_TAKEN  = br;
        BRANCH_TARGET = tgt;
        PC            = m_pc;
        IMEM_READDATA = mem_word(m_addr);
        #1;
        complete = m_busy && !bw;
        push     = complete && !m_wrong && !br;
        pop      = (q.size() > 0) && !ids && !br;
        cnt_next = q.size() + int'(push) - int'(pop);
        issue    = !rst && !br && (!m_busy || (complete && !m_wrong)) && (cnt_next < DEPTH);
        stall    = rst || (!issue && !br);
        pc_next  = br ? tgt : m_pc + 32'd4;

        check_eq("fetch_stall", 32'(FETCH_STALL), 32'(stall));
        check_eq("pc_next", PC_NEXT, pc_next);
        check_eq("imem_read", 32'(IMEM_READ), 32'(m_busy));
        if (m_busy) check_eq("imem_addr", IMEM_ADDR, m_addr);
        check_eq("if_valid", 32'(IF_VALID), 32'(q.size() > 0));
        if (q.size() > 0) begin
            check_eq("if_pc", IF_PC, q[0].pc);
            check_eq("if_instr", IF_INSTR, q[0].instr);
            check_eq("if_pc4", IF_PC4, q[0].pc + 32'd4);
        end else begin
            check_eq("if_pc_empty", IF_PC, 32'd0);
            check_eq("if_instr_empty", IF_INSTR, NOP);
            check_eq("if_pc4_empty", IF_PC4, 32'd4);
        end

        @(posedge CLOCK);
        if (rst) begin
            q.delete();
            m_busy  = 1'b0;
            m_wrong = 1'b0;
            m_addr  = '0;
            m_pc    = '0;
        end else begin
            if (br) begin
                q.delete();
            end else begin
                if (pop) void'(q.pop_front());
                if (push) q.push_back('{pc: m_addr, instr: mem_word(m_addr)});
            end
            if (issue) begin
                m_busy  = 1'b1;
                m_wrong = 1'b0;
                m_addr  = m_pc;
            end else if (complete) begin
                m_busy  = 1'b0;
                m_wrong = 1'b0;
            end else if (br && m_busy) begin
                m_wrong = 1'b1;
            end
            if (!stall) m_pc = pc_next;
        end
    endtask

    initial begin
        int p_bw, p_ids, p_br, p_rst;

        repeat (2) step(1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
        #1;
        check_eq("rst_imem_read", 32'(IMEM_READ), 32'd0);
        check_eq("rst_imem_addr", IMEM_ADDR, 32'd0);
        check_eq("rst_if_valid", 32'(IF_VALID), 32'd0);
        check_eq("rst_if_instr", IF_INSTR, NOP);

        // Streaming from PC=0 with a zero-wait memory
        repeat (20) step(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);

        // Redirect near the top of the address space to exercise PC+4 wrap
        step(1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFF8);
        repeat (6) step(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);

        // Memory wait states
        step(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0010);
        repeat (3) step(1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
        repeat (4) step(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);

        // Redirect while a request is stuck busy
        step(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0020);
        step(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        step(1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_0100);
        step(1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
        repeat (5) step(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);

        // Decode back-pressure fills the queue, then drains in order
        repeat (5) step(1'b0, 1'b0, 1'b1, 1'b0, 32'd0);
        repeat (5) step(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);

        // Redirect with a full queue and a completing request
        repeat (4) step(1'b0, 1'b0, 1'b1, 1'b0, 32'd0);
        step(1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0200);
        repeat (4) step(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);

        // Reset while a request is open and busy
        step(1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 32'd0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
        repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);

        // Randomized traffic with changing pressure per block
        for (int blk = 0; blk < 8; blk++) begin
            p_bw  = (blk % 4) * 20;
            p_ids = ((blk + 1) % 4) * 20;
            p_br  = (blk < 4) ? 5 : 15;
            p_rst = (blk == 7) ? 3 : 0;
            for (int c = 0; c < 100; c++) begin
                step(($urandom_range(0, 99) < p_rst),
                     ($urandom_range(0, 99) < p_bw),
                     ($urandom_range(0, 99) < p_ids),
                     ($urandom_range(0, 99) < p_br),
                     {$urandom_range(0, 32'h3FFF_FFFF), 2'b00});
            end
        end

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
